// File: rtl/clause_queue.sv
// First-word-fall-through queue of clauses between the clause arbiter and the downstream engine.
// Flags derive from registered occupancy only; pushes that find no room are dropped and latched.
module clause_queue #(
    parameter int unsigned CLAUSE_WIDTH    = 4,
    parameter int unsigned ELEMENT_BIT_CNT = 11,
    parameter int unsigned DEPTH           = 8
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    push_in,
    input  logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_in,
    input  logic                                    pop_in,
    input  logic                                    flush_in,
    output logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_out,
    output logic                                    valid_out,
    output logic                                    full_out,
    output logic                                    empty_out,
    output logic [$clog2(DEPTH):0]                  count_out,
    output logic                                    overflow_out
);

    localparam int unsigned DW = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic full, empty;
    logic pop_acc, push_acc, push_drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Flush discards both requests; a pop on a full queue frees the slot for a same-edge push.
    assign pop_acc   = pop_in && !empty && !flush_in;
    assign push_acc  = push_in && !flush_in && (!full || pop_acc);
    assign push_drop = push_in && !flush_in && full && !pop_acc;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_in) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push_drop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset: its contents are never visible while the queue is empty.
    always_ff @(posedge clock) begin
        if (push_acc) mem_q[wr_ptr_q] <= clause_in;
    end

    always_comb begin
        clause_out   = empty ? '0 : mem_q[rd_ptr_q];
        valid_out    = !empty;
        full_out     = full;
        empty_out    = empty;
        count_out    = count_q;
        overflow_out = overflow_q;
    end

endmodule

// File: tb/tb_clause_queue.sv
// Directed self-checking bench for clause_queue at default parameters (44-bit clauses, depth 8).
module tb_clause_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        push_in, pop_in, flush_in;
    logic [43:0] clause_in;
    logic [43:0] clause_out;
    logic        valid_out, full_out, empty_out, overflow_out;
    logic [3:0]  count_out;

    int n_checks = 0;
    int n_fail   = 0;

    clause_queue dut (
        .clock        (clock),
        .reset        (reset),
        .push_in      (push_in),
        .clause_in    (clause_in),
        .pop_in       (pop_in),
        .flush_in     (flush_in),
        .clause_out   (clause_out),
        .valid_out    (valid_out),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .count_out    (count_out),
        .overflow_out (overflow_out)
    );

    always #5 clock = ~clock;

    // Drive one cycle of requests, clock it, and return 1 time unit after the edge.
    task automatic cycle(input logic push, input logic pop, input logic flush,
                         input logic [43:0] data);
        push_in   = push;
        pop_in    = pop;
        flush_in  = flush;
        clause_in = data;
        @(posedge clock);
        #1;
        push_in  = 1'b0;
        pop_in   = 1'b0;
        flush_in = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        push_in = 1'b0; pop_in = 1'b0; flush_in = 1'b0; clause_in = '0;
        #12;
        n_checks++;
        if ({count_out, empty_out, full_out, valid_out, overflow_out} !== {4'd0, 4'b1000}) begin
            $display("FAIL reset_flags: cnt=%0d e=%b f=%b v=%b o=%b want cnt=0 e=1 f=0 v=0 o=0",
                     count_out, empty_out, full_out, valid_out, overflow_out);
            n_fail++;
        end
        n_checks++;
        if (clause_out !== 44'd0) begin
            $display("FAIL reset_clause: got %h want 0", clause_out);
            n_fail++;
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 44'h0AB_0CD_0EF_012);
        n_checks++;
        if (valid_out !== 1'b1 || count_out !== 4'd1) begin
            $display("FAIL first_push_flags: v=%b cnt=%0d want v=1 cnt=1", valid_out, count_out);
            n_fail++;
        end
        n_checks++;
        if (clause_out !== 44'h0AB_0CD_0EF_012) begin
            $display("FAIL first_push_data: got %h want 0ab0cd0ef012", clause_out);
            n_fail++;
        end
        cycle(1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b0, 44'(i));
        n_checks++;
        if (full_out !== 1'b1 || count_out !== 4'd8 || overflow_out !== 1'b0) begin
            $display("FAIL fill_full: f=%b cnt=%0d o=%b want f=1 cnt=8 o=0",
                     full_out, count_out, overflow_out);
            n_fail++;
        end
        cycle(1'b1, 1'b0, 1'b0, 44'd9);
        n_checks++;
        if (overflow_out !== 1'b1 || count_out !== 4'd8 || clause_out !== 44'd1) begin
            $display("FAIL fill_drop: o=%b cnt=%0d head=%0d want o=1 cnt=8 head=1",
                     overflow_out, count_out, clause_out);
            n_fail++;
        end
        for (int i = 1; i <= 8; i++) begin
            n_checks++;
            if (clause_out !== 44'(i)) begin
                $display("FAIL fill_pop_order: got %0d want %0d", clause_out, i);
                n_fail++;
            end
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        n_checks++;
        if (empty_out !== 1'b1 || valid_out !== 1'b0 || overflow_out !== 1'b1) begin
            $display("FAIL fill_drained: e=%b v=%b o=%b want e=1 v=0 o=1 (sticky)",
                     empty_out, valid_out, overflow_out);
            n_fail++;
        end
        cycle(1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic test_full_push_pop;
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b0, 44'(i));
        cycle(1'b1, 1'b1, 1'b0, 44'd9);
        n_checks++;
        if (clause_out !== 44'd2 || count_out !== 4'd8 || full_out !== 1'b1
            || overflow_out !== 1'b0) begin
            $display("FAIL full_pp: head=%0d cnt=%0d f=%b o=%b want head=2 cnt=8 f=1 o=0",
                     clause_out, count_out, full_out, overflow_out);
            n_fail++;
        end
        for (int i = 2; i <= 9; i++) begin
            n_checks++;
            if (clause_out !== 44'(i)) begin
                $display("FAIL full_pp_order: got %0d want %0d", clause_out, i);
                n_fail++;
            end
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
        n_checks++;
        if (empty_out !== 1'b1) begin
            $display("FAIL full_pp_empty: e=%b want 1", empty_out);
            n_fail++;
        end
    endtask

    task automatic test_empty_push_pop;
        cycle(1'b1, 1'b1, 1'b0, 44'h55);
        n_checks++;
        if (count_out !== 4'd1 || clause_out !== 44'h55) begin
            $display("FAIL empty_pp: cnt=%0d head=%h want cnt=1 head=55", count_out, clause_out);
            n_fail++;
        end
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (count_out !== 4'd0 || clause_out !== 44'd0 || empty_out !== 1'b1) begin
            $display("FAIL pop_on_empty: cnt=%0d head=%h e=%b want cnt=0 head=0 e=1",
                     count_out, clause_out, empty_out);
            n_fail++;
        end
    endtask

    task automatic test_wrap;
        logic [43:0] model [$];
        logic [43:0] v;
        int next = 100;
        for (int i = 0; i < 3; i++) begin
            v = 44'(next++);
            model.push_back(v);
            cycle(1'b1, 1'b0, 1'b0, v);
        end
        // Occupancy walks 3,4,5,4,3 while both pointers travel past the end of storage.
        for (int c = 0; c < 20; c++) begin
            if ((c % 4) < 2) begin
                v = 44'(next++);
                model.push_back(v);
                cycle(1'b1, 1'b0, 1'b0, v);
            end else begin
                n_checks++;
                if (clause_out !== model[0]) begin
                    $display("FAIL wrap_order: cycle %0d got %0d want %0d", c, clause_out, model[0]);
                    n_fail++;
                end
                void'(model.pop_front());
                cycle(1'b0, 1'b1, 1'b0, '0);
            end
            n_checks++;
            if (count_out !== 4'(model.size())) begin
                $display("FAIL wrap_count: cycle %0d got %0d want %0d",
                         c, count_out, model.size());
                n_fail++;
            end
        end
        while (model.size() > 0) begin
            n_checks++;
            if (clause_out !== model[0]) begin
                $display("FAIL wrap_drain: got %0d want %0d", clause_out, model[0]);
                n_fail++;
            end
            void'(model.pop_front());
            cycle(1'b0, 1'b1, 1'b0, '0);
        end
    endtask

    task automatic test_flush_reset;
        for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, 1'b0, 44'(i));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        n_checks++;
        if (count_out !== 4'd5 || overflow_out !== 1'b1) begin
            $display("FAIL pre_flush: cnt=%0d o=%b want cnt=5 o=1", count_out, overflow_out);
            n_fail++;
        end
        cycle(1'b1, 1'b0, 1'b1, 44'hABC);
        n_checks++;
        if (count_out !== 4'd0 || overflow_out !== 1'b0 || empty_out !== 1'b1
            || clause_out !== 44'd0) begin
            $display("FAIL flush: cnt=%0d o=%b e=%b head=%h want cnt=0 o=0 e=1 head=0",
                     count_out, overflow_out, empty_out, clause_out);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 44'(20 + i));
        n_checks++;
        if (count_out !== 4'd3 || clause_out !== 44'd20) begin
            $display("FAIL pre_reset: cnt=%0d head=%0d want cnt=3 head=20", count_out, clause_out);
            n_fail++;
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({count_out, empty_out, full_out, valid_out, overflow_out} !== {4'd0, 4'b1000}
            || clause_out !== 44'd0) begin
            $display("FAIL async_reset: cnt=%0d e=%b v=%b head=%h want cnt=0 e=1 v=0 head=0",
                     count_out, empty_out, valid_out, clause_out);
            n_fail++;
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cycle(1'b1, 1'b0, 1'b0, 44'h777);
        n_checks++;
        if (count_out !== 4'd1 || clause_out !== 44'h777) begin
            $display("FAIL post_reset: cnt=%0d head=%h want cnt=1 head=777", count_out, clause_out);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_empty_push_pop();
        test_wrap();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
